// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG scan front end and the chained register RAM wrapper.
package jtag_pkg;
    localparam int JTAG_WIDTH = 32;
    localparam int JTAG_DEPTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        XFER,
        LOAD,
        DONE
    } jtag_state_e;
endpackage

// File: rtl/jtag_shift_word.sv
// One word of serial/parallel conversion: TDI assembles into in_sr while out_sr drains onto TDO.
module jtag_shift_word #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             clr_i,
    input  logic             tdi_i,
    input  logic [WIDTH-1:0] par_i,
    output logic [WIDTH-1:0] in_sr_o,
    output logic             sout_o,
    output logic             word_full_o
);
    logic [WIDTH-1:0] in_sr_q, in_sr_d;
    logic [WIDTH-1:0] out_sr_q, out_sr_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    // Asserted on the strobe that delivers the last bit of a word.
    assign word_full_o = shift_i && (bit_cnt_q == CNT_W'(WIDTH - 1));
    assign in_sr_o     = in_sr_q;
    assign sout_o      = out_sr_q[0];

    always_comb begin
        in_sr_d   = in_sr_q;
        out_sr_d  = out_sr_q;
        bit_cnt_d = bit_cnt_q;
        if (clr_i)
            bit_cnt_d = '0;
        if (load_i)
            out_sr_d = par_i;
        if (shift_i) begin
            in_sr_d   = {tdi_i, in_sr_q[WIDTH-1:1]};
            out_sr_d  = out_sr_q >> 1;
            bit_cnt_d = word_full_o ? '0 : bit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_sr_q   <= '0;
            out_sr_q  <= '0;
            bit_cnt_q <= '0;
        end else begin
            in_sr_q   <= in_sr_d;
            out_sr_q  <= out_sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end
endmodule

// File: rtl/jtag_scan_ctrl.sv
// Scan sequencer: shifts DEPTH words through the register RAM chain, one Jen pulse per word.
module jtag_scan_ctrl
    import jtag_pkg::*;
#(
    parameter int WIDTH = JTAG_WIDTH,
    parameter int DEPTH = JTAG_DEPTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_en,
    input  logic             tdi,
    output logic             tdo,
    output logic             busy,
    output logic             done,
    output logic             Jen,
    output logic [WIDTH-1:0] Jin,
    input  logic [WIDTH-1:0] Jout
);
    localparam int WC_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    jtag_state_e     state_q, state_d;
    logic [WC_W-1:0] word_cnt_q, word_cnt_d;
    logic            load, shift, clr, word_full;

    jtag_shift_word #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_word (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .shift_i     (shift),
        .clr_i       (clr),
        .tdi_i       (tdi),
        .par_i       (Jout),
        .in_sr_o     (Jin),
        .sout_o      (tdo),
        .word_full_o (word_full)
    );

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        load       = 1'b0;
        shift      = 1'b0;
        clr        = 1'b0;
        Jen        = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                state_d    = SHIFT;
                load       = 1'b1;
                clr        = 1'b1;
                word_cnt_d = '0;
            end
            SHIFT: if (bit_en) begin
                shift = 1'b1;
                if (word_full)
                    state_d = XFER;
            end
            XFER: begin
                Jen     = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                // The RAM shifted on the previous edge, so Jout is already the next tail word.
                load = 1'b1;
                if (word_cnt_q == WC_W'(DEPTH - 1)) begin
                    state_d = DONE;
                end else begin
                    word_cnt_d = word_cnt_q + WC_W'(1);
                    state_d    = SHIFT;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d    = IDLE;
            word_cnt_d = word_cnt_q;
            load       = 1'b0;
            shift      = 1'b0;
            clr        = 1'b0;
            Jen        = 1'b0;
            done       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
        end
    end
endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Randomized bench: a behavioural chained RAM plus expected scan ordering derived from the chain direction.
module tb_jtag_scan_ctrl;
    import jtag_pkg::*;
    localparam int W = JTAG_WIDTH;
    localparam int D = JTAG_DEPTH;

    logic clk = 0, rst_n = 0, start = 0, abort = 0, bit_en = 0, tdi = 0;
    logic tdo, busy, done, Jen;
    logic [W-1:0] Jin, Jout;

    logic         wen = 0;
    int           waddr = 0;
    logic [W-1:0] wdin = '0;
    logic [W-1:0] ram [D];
    logic [W-1:0] wv [D], old [D], got [D];
    logic [W-1:0] tmp;
    int errs = 0, checks = 0, jen_cnt = 0, done_cnt = 0, jen0 = 0, done0 = 0;
    logic poke = 0;

    always #5 clk = ~clk;

    jtag_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bit_en(bit_en),
        .tdi(tdi), .tdo(tdo), .busy(busy), .done(done), .Jen(Jen), .Jin(Jin), .Jout(Jout)
    );

    // Chain Jin -> reg0 -> ... -> reg(D-1) -> Jout; Wen port for preloading.
    assign Jout = ram[D-1];
    always @(posedge clk) begin
        if (Jen) begin
            jen_cnt <= jen_cnt + 1;
            ram[0]  <= Jin;
            for (int k = 1; k < D; k++) ram[k] <= ram[k-1];
        end else if (wen) begin
            ram[waddr] <= wdin;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [W-1:0] g, input logic [W-1:0] e);
        checks++;
        if (g !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, g, e);
        end
    endtask

    task automatic preload(input bit rnd);
        for (int k = 0; k < D; k++) begin
            wen = 1; waddr = k; wdin = rnd ? W'($urandom) : (32'h1000_0000 | W'(k));
            @(negedge clk);
        end
        wen = 0;
    endtask

    task automatic set_words(input bit rnd);
        for (int i = 0; i < D; i++) wv[i] = rnd ? W'($urandom) : (32'hA5A5_0000 + W'(i));
    endtask

    task automatic begin_scan();
        old = ram; jen0 = jen_cnt; done0 = done_cnt;
        start = 1; @(negedge clk);
        start = 0;
    endtask

    // Two idle cycles lead each word so no strobe lands in XFER/LOAD.
    task automatic strobe_word(input logic [W-1:0] w, input int glo, input int ghi,
                               input int nbits, output logic [W-1:0] g);
        int n;
        g = '0;
        for (int b = 0; b < nbits; b++) begin
            n = (b == 0) ? 2 : int'($urandom_range(ghi, glo));
            for (int k = 0; k < n; k++) begin
                bit_en = 0; start = 0; tdi = 1'($urandom); @(negedge clk);
            end
            bit_en = 1; tdi = w[b]; start = poke && (b == 5); g[b] = tdo;
            @(negedge clk);
        end
        bit_en = 0; start = 0;
    endtask

    task automatic run_scan(input int glo, input int ghi, input bit pk, input string tag);
        begin_scan();
        for (int i = 0; i < D; i++) begin
            poke = pk && (i == 3);
            strobe_word(wv[i], glo, ghi, W, got[i]);
            poke = 0;
        end
        for (int k = 0; k < 10 && done_cnt == done0; k++) @(negedge clk);
        chk({tag, "_done"}, W'(done_cnt - done0), 1);
        @(negedge clk);
        chk({tag, "_idle"}, W'(busy), 0);
        chk({tag, "_done1"}, W'(done_cnt - done0), 1);
        chk({tag, "_jen"}, W'(jen_cnt - jen0), W'(D));
        for (int i = 0; i < D; i++) chk($sformatf("%s_tdo%0d", tag, i), got[i], old[D-1-i]);
        for (int k = 0; k < D; k++) chk($sformatf("%s_ram%0d", tag, k), ram[k], wv[D-1-k]);
    endtask

    initial begin
        #1;
        chk("rst_tdo", W'(tdo), 0); chk("rst_busy", W'(busy), 0); chk("rst_done", W'(done), 0);
        chk("rst_jen", W'(Jen), 0); chk("rst_jin", Jin, 0);
        @(negedge clk); rst_n = 1; @(negedge clk);

        preload(0); set_words(0); run_scan(0, 0, 0, "full");
        chk("full_rd7", ram[7], 32'hA5A5_0000); chk("full_rd0", ram[0], 32'hA5A5_0007);
        preload(0); set_words(0); run_scan(2, 2, 0, "gap3");
        preload(1); set_words(1); run_scan(0, 1, 1, "poke");

        // Abort part-way into word 3 after three transfers.
        preload(0); set_words(1); begin_scan();
        for (int i = 0; i < 3; i++) strobe_word(wv[i], 0, 2, W, got[i]);
        strobe_word(wv[3], 0, 0, 10, tmp);
        abort = 1; @(negedge clk); abort = 0;
        chk("ab_busy", W'(busy), 0); chk("ab_jen", W'(jen_cnt - jen0), 3);
        @(negedge clk); chk("ab_nodone", W'(done_cnt - done0), 0);
        for (int i = 0; i < 3; i++) chk($sformatf("ab_tdo%0d", i), got[i], old[D-1-i]);
        for (int k = 0; k < D; k++) chk($sformatf("ab_ram%0d", k), ram[k], (k < 3) ? wv[2-k] : old[k-3]);

        // Abort landing exactly on the transfer cycle.
        begin_scan(); strobe_word(wv[0], 0, 0, W, tmp);
        abort = 1; #1;
        chk("abx_jen", W'(Jen), 0); chk("abx_busy", W'(busy), 1);
        @(negedge clk); abort = 0;
        chk("abx_idle", W'(busy), 0); chk("abx_cnt", W'(jen_cnt - jen0), 0);
        for (int k = 0; k < D; k++) chk($sformatf("abx_ram%0d", k), ram[k], old[k]);

        // Reset mid-SHIFT: outputs drop without waiting for a clock.
        preload(0); begin_scan(); strobe_word(32'hFFFF_FFFF, 0, 0, 2, tmp);
        chk("rs_pre_tdo", W'(tdo), 1); chk("rs_pre_busy", W'(busy), 1);
        rst_n = 0; #1;
        chk("rs_jen", W'(Jen), 0); chk("rs_busy", W'(busy), 0);
        chk("rs_tdo", W'(tdo), 0); chk("rs_jin", Jin, 0);
        @(negedge clk); rst_n = 1; @(negedge clk);
        chk("rs_idle", W'(busy), 0); chk("rs_nodone", W'(done_cnt - done0), 0);

        // Reset during XFER removes Jen asynchronously and the RAM does not shift.
        begin_scan(); strobe_word(32'h1234_5678, 0, 0, W, tmp);
        chk("rx_pre_jen", W'(Jen), 1);
        rst_n = 0; #1; chk("rx_jen", W'(Jen), 0);
        @(negedge clk); rst_n = 1; @(negedge clk);
        chk("rx_cnt", W'(jen_cnt - jen0), 0); chk("rx_ram7", ram[D-1], old[D-1]);

        for (int r = 0; r < 3; r++) begin
            preload(1); set_words(1); run_scan(0, 4, 0, $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/jtag_scan_ctrl.md
Name: jtag_scan_ctrl

Overview:
Bit-serial scan front end that sits directly upstream of the 8x32 JTAG-chained register RAM. It assembles serial TDI bits into words, presents each word on the RAM's Jin bus and pulses Jen for one cycle. It also captures each word leaving the chain on Jout and serialises it onto TDO. One scan replaces the whole RAM contents and reads the old contents out.

Parameters:
WIDTH, 32, word width; equals the RAM Jin/Jout width
DEPTH, 8, words per scan; equals the RAM register count
CNT_W, $clog2(WIDTH), bit counter width

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  begin a scan; sampled in IDLE only
abort  in  1  synchronous cancel; overrides all other inputs except reset
bit_en  in  1  serial bit strobe; one TDI/TDO bit per cycle with bit_en=1
tdi  in  1  serial data in, LSB of each word first
tdo  out  1  serial data out; always out_sr[0] (registered state, no combinational input path)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a scan completes
Jen  out  1  one-cycle chain-shift enable to the RAM
Jin  out  WIDTH  always equals in_sr
Jout  in  WIDTH  word currently at the tail of the RAM chain

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_sr=0; out_sr=0; bit_cnt=0; word_cnt=0. Outputs: tdo=0, busy=0, done=0, Jen=0, Jin=0.
- States: IDLE, SHIFT, XFER, LOAD, DONE.
- IDLE:
  - start=1 -> SHIFT, with out_sr<=Jout, bit_cnt<=0, word_cnt<=0.
  - tdi and bit_en are ignored.
- SHIFT, on a cycle with bit_en=1:
  - in_sr<={tdi,in_sr[WIDTH-1:1]}; out_sr<=out_sr>>1; bit_cnt++.
  - On the strobe where bit_cnt==WIDTH-1 -> XFER, with bit_cnt<=0.
  - Cycles with bit_en=0 hold all state; strobe gaps of any length are legal.
- XFER: Jen=1 for exactly this one cycle; Jin=in_sr holds the full word; next state LOAD.
- LOAD:
  - out_sr<=Jout, which is the new chain tail after the RAM shift.
  - If word_cnt==DEPTH-1 -> DONE; else word_cnt++ and -> SHIFT.
  - bit_en is ignored in XFER and LOAD, so a bit strobed there is dropped; the host must not strobe in these two cycles.
- DONE: done=1 for one cycle, then -> IDLE.
- Scan ordering, chain direction Jin->reg0->...->reg(DEPTH-1)->Jout:
  - The first word out on tdo is the old reg(DEPTH-1), the last is the old reg0.
  - The first word in ends in reg(DEPTH-1), the last word in ends in reg0.
  - A full scan issues exactly DEPTH Jen pulses and takes DEPTH*WIDTH strobes.
- start while busy: ignored.
- abort=1 in any non-IDLE state -> IDLE at the next edge, with Jen=0 and no done pulse; the partial word is discarded.
  - RAM words already transferred stay shifted.
  - abort in the XFER cycle suppresses that cycle's Jen.
- Reset mid-scan: immediate return to the reset values; Jen is deasserted asynchronously.
- Wen/Din RAM writes must not coincide with Jen; the host guarantees this (busy is the interlock).

Decomposition:
- Shared package jtag_pkg holds:
  - the state enum (IDLE, SHIFT, XFER, LOAD, DONE);
  - constants JTAG_WIDTH=32 and JTAG_DEPTH=8, also used by the RAM wrapper.
- Natural sub-module: jtag_shift_word. It is the WIDTH-bit parallel-load/serial-shift pair (in_sr/out_sr plus bit_cnt) with a word_full flag.
- The FSM and word_cnt stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT -> same cycle: Jen=0, busy=0, tdo=0, Jin=0; after release, IDLE.
- Full scan:
  - Stimulus: preload RAM regk=0x1000_000k via Wen; start; strobe words 0xA5A5_0000+i (i=0..7) LSB first, continuous bit_en.
  - Response: tdo yields 0x10000007, 0x10000006, ..., 0x10000000; exactly 8 Jen pulses; done one cycle.
  - Final readback: Addr7 reads 0xA5A50000 and Addr0 reads 0xA5A50007.
- Strobe gaps: same scan with bit_en=1 every 3rd cycle -> identical tdo stream and final RAM, 256 strobes total.
- Abort: abort after the 3rd Jen pulse, mid-word 4 -> no done; RAM contents shifted by exactly 3 words; busy=0 next cycle.
- Busy interlock: start pulsed during SHIFT -> no state or counter change; the scan completes normally with exactly 8 Jen pulses.
